pid_decoder: RTL and testbench

PID_DECODER -- requirements
Module: pid_decoder

---
 rtl/pid_decoder.sv | 194 +++++++++++++++++++
 tb/tb_pid_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pid_decoder
// Description : USB packet PID decoder: classifies packets, counts payload
//               bytes, flags PID/length errors and tracks per-endpoint toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_decoder #(
    parameter int NUM_EP    = 4,
    parameter int MAX_BYTES = 1026,
    parameter int CNT_W     = $clog2(MAX_BYTES + 2),
    localparam int EP_W     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SOP_flag,
    input  logic             EOP_flag,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic [EP_W-1:0]  ep_addr,
    output logic [2:0]       data_select,
    output logic             crc5_enable,
    output logic             crc16_enable,
    output logic [3:0]       pid_out,
    output logic [CNT_W-1:0] byte_count,
    output logic             pid_err,
    output logic             len_err,
    output logic             toggle_err,
    output logic             pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PID = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_DROP     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [2:0]       c_cls_token = 3'b000;
    localparam logic [2:0]       c_cls_data  = 3'b001;
    localparam logic [2:0]       c_cls_hshk  = 3'b010;
    localparam logic [2:0]       c_cls_spec  = 3'b011;
    localparam logic [2:0]       c_cls_none  = 3'b100;
    localparam logic [3:0]       c_pid_setup = 4'b1101;
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_cnt_sat   = CNT_W'(MAX_BYTES + 1);

    state_t            r_state;
    logic [NUM_EP-1:0] r_exp_tog;

    logic              w_pid_ok;
    logic [2:0]        w_class;
    logic              w_len_err_nxt;
    logic [3:0]        w_eop_pid;
    logic              w_eop_ok;
    logic [NUM_EP-1:0] w_tog_nxt;
    logic              w_tog_err;

    function automatic logic [2:0] pid_class(input logic [3:0] p);
        case (p)
            4'b0001, 4'b1001, 4'b0101, 4'b1101: pid_class = c_cls_token;
            4'b0011, 4'b1011, 4'b0111, 4'b1111: pid_class = c_cls_data;
            4'b0010, 4'b1010, 4'b0110, 4'b1110: pid_class = c_cls_hshk;
            4'b1100, 4'b1000, 4'b0100:          pid_class = c_cls_spec;
            default:                            pid_class = c_cls_none;
        endcase
    endfunction

    assign w_pid_ok      = (byte_in[7:4] == ~byte_in[3:0]);
    assign w_class       = pid_class(byte_in[3:0]);
    assign w_len_err_nxt = len_err | ((r_state == S_PAYLOAD) && byte_valid &&
                                      (byte_count >= c_cnt_max));

    // A PID byte arriving together with EOP is resolved in the same cycle.
    always_comb begin
        w_eop_pid = pid_out;
        w_eop_ok  = (r_state == S_PAYLOAD) && !pid_err && !w_len_err_nxt;
        if ((r_state == S_WAIT_PID) && byte_valid) begin
            w_eop_pid = byte_in[3:0];
            w_eop_ok  = w_pid_ok;
        end
    end

    always_comb begin
        w_tog_nxt = r_exp_tog;
        w_tog_err = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (w_eop_ok && (ep_addr == EP_W'(i))) begin
                if (w_eop_pid == c_pid_setup) begin
                    w_tog_nxt[i] = 1'b0;
                end else if (w_eop_pid[2:0] == 3'b011) begin
                    if (w_eop_pid[3] == r_exp_tog[i]) begin
                        w_tog_nxt[i] = ~r_exp_tog[i];
                    end else begin
                        w_tog_err = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_exp_tog    <= '0;
            data_select  <= c_cls_none;
            crc5_enable  <= 1'b0;
            crc16_enable <= 1'b0;
            pid_out      <= 4'b0000;
            byte_count   <= '0;
            pid_err      <= 1'b0;
            len_err      <= 1'b0;
            toggle_err   <= 1'b0;
            pkt_done     <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (SOP_flag) begin
                r_state      <= S_WAIT_PID;
                data_select  <= c_cls_none;
                crc5_enable  <= 1'b0;
                crc16_enable <= 1'b0;
                pid_out      <= 4'b0000;
                byte_count   <= '0;
                pid_err      <= 1'b0;
                len_err      <= 1'b0;
                toggle_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_WAIT_PID: begin
                        if (byte_valid) begin
                            if (w_pid_ok) begin
                                pid_out      <= byte_in[3:0];
                                data_select  <= w_class;
                                crc5_enable  <= (w_class == c_cls_token);
                                crc16_enable <= (w_class == c_cls_data);
                                r_state      <= S_PAYLOAD;
                            end else begin
                                pid_err      <= 1'b1;
                                data_select  <= c_cls_none;
                                crc5_enable  <= 1'b0;
                                crc16_enable <= 1'b0;
                                r_state      <= S_DROP;
                            end
                        end else if (EOP_flag) begin
                            pid_err <= 1'b1;
                        end
                        if (EOP_flag) begin
                            r_state      <= S_DONE;
                            pkt_done     <= 1'b1;
                            crc5_enable  <= 1'b0;
                            crc16_enable <= 1'b0;
                            r_exp_tog    <= w_tog_nxt;
                            toggle_err   <= w_tog_err;
                        end
                    end
                    S_PAYLOAD: begin
                        if (byte_valid) begin
                            if (byte_count != c_cnt_sat) begin
                                byte_count <= byte_count + CNT_W'(1);
                            end
                            len_err <= w_len_err_nxt;
                        end
                        if (EOP_flag) begin
                            r_state      <= S_DONE;
                            pkt_done     <= 1'b1;
                            crc5_enable  <= 1'b0;
                            crc16_enable <= 1'b0;
                            r_exp_tog    <= w_tog_nxt;
                            toggle_err   <= w_tog_err;
                        end
                    end
                    S_DROP: begin
                        if (EOP_flag) begin
                            r_state  <= S_DONE;
                            pkt_done <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pid_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_decoder
// Description : Scoreboard bench for pid_decoder with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_decoder;

    localparam int NUM_EP    = 3;
    localparam int MAX_BYTES = 4;
    localparam int CNT_W     = $clog2(MAX_BYTES + 2);
    localparam int EP_W      = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             SOP_flag = 1'b0;
    logic             EOP_flag = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_valid = 1'b0;
    logic [EP_W-1:0]  ep_addr = '0;
    logic [2:0]       data_select;
    logic             crc5_enable;
    logic             crc16_enable;
    logic [3:0]       pid_out;
    logic [CNT_W-1:0] byte_count;
    logic             pid_err;
    logic             len_err;
    logic             toggle_err;
    logic             pkt_done;

    pid_decoder #(.NUM_EP(NUM_EP), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .SOP_flag(SOP_flag), .EOP_flag(EOP_flag),
        .byte_in(byte_in), .byte_valid(byte_valid), .ep_addr(ep_addr),
        .data_select(data_select), .crc5_enable(crc5_enable),
        .crc16_enable(crc16_enable), .pid_out(pid_out), .byte_count(byte_count),
        .pid_err(pid_err), .len_err(len_err), .toggle_err(toggle_err),
        .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        ds;
        logic              c5;
        logic              c16;
        logic [3:0]        pid;
        logic [7:0]        cnt;
        logic              pe;
        logic              le;
        logic              te;
        logic [NUM_EP-1:0] tog;
    } exp_t;

    exp_t              sb_q[$];
    logic [NUM_EP-1:0] m_tog = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] cls(input logic [3:0] p);
        case (p)
            4'h1, 4'h9, 4'h5, 4'hD: return 3'd0;
            4'h3, 4'hB, 4'h7, 4'hF: return 3'd1;
            4'h2, 4'hA, 4'h6, 4'hE: return 3'd2;
            4'hC, 4'h8, 4'h4:       return 3'd3;
            default:                return 3'd4;
        endcase
    endfunction

    // Packet-level reference: outcome of one whole packet plus toggle update.
    function automatic exp_t model_pkt(input bit has_pid, input logic [7:0] pb,
                                       input int nbytes, input int ep);
        exp_t       e;
        logic [3:0] p;
        e = '0;
        e.ds = 3'd4;
        p = pb[3:0];
        if (!has_pid || (pb[7:4] != ~pb[3:0])) begin
            e.pe = 1'b1;
        end else begin
            e.pid = p;
            e.ds  = cls(p);
            e.c5  = (e.ds == 3'd0);
            e.c16 = (e.ds == 3'd1);
            e.cnt = 8'((nbytes > MAX_BYTES) ? MAX_BYTES + 1 : nbytes);
            e.le  = (nbytes > MAX_BYTES);
            if (!e.le && ep < NUM_EP) begin
                if (p == 4'hD) begin
                    m_tog[ep] = 1'b0;
                end else if (p == 4'h3 || p == 4'hB) begin
                    if (p[3] == m_tog[ep]) m_tog[ep] = ~m_tog[ep];
                    else e.te = 1'b1;
                end
            end
        end
        e.tog = m_tog;
        return e;
    endfunction

    task automatic send_pkt(input bit has_pid, input logic [7:0] pb, input int nbytes,
                            input int ep, input bit coincide);
        bit eop_sent = 0;
        sb_q.push_back(model_pkt(has_pid, pb, nbytes, ep));
        SOP_flag = 1'b1;
        tick();
        SOP_flag = 1'b0;
        if (has_pid) begin
            byte_valid = 1'b1;
            byte_in    = pb;
            tick();
            byte_valid = 1'b0;
        end
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            if (i == nbytes - 1 && coincide) begin
                EOP_flag = 1'b1;
                ep_addr  = EP_W'(ep);
                eop_sent = 1;
            end
            tick();
            byte_valid = 1'b0;
        end
        if (!eop_sent) begin
            EOP_flag = 1'b1;
            ep_addr  = EP_W'(ep);
            tick();
        end
        EOP_flag = 1'b0;
        chk("pkt_done_after_eop", 32'(pkt_done), 32'd1);
        tick();
        chk("pkt_done_one_cycle", 32'(pkt_done), 32'd0);
        tick();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ds"},   32'(data_select), 32'd4);
        chk({nm, "_crc"},  32'({crc5_enable, crc16_enable}), 32'd0);
        chk({nm, "_pid"},  32'(pid_out), 32'd0);
        chk({nm, "_cnt"},  32'(byte_count), 32'd0);
        chk({nm, "_errs"}, 32'({pid_err, len_err, toggle_err}), 32'd0);
        chk({nm, "_done"}, 32'(pkt_done), 32'd0);
        chk({nm, "_tog"},  32'(dut.r_exp_tog), 32'd0);
    endtask

    // Monitor: pops one expectation per pkt_done pulse.
    initial begin
        exp_t e;
        bit   prev_done = 0;
        bit   l5 = 0;
        bit   l16 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_done = 0;
                l5 = 0;
                l16 = 0;
            end else begin
                if (pkt_done) begin
                    if (prev_done) begin
                        chk("done_pulse_width", 32'd1, 32'd0);
                    end else if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("data_select", 32'(data_select), 32'(e.ds));
                        chk("crc5_in_pkt", 32'(l5), 32'(e.c5));
                        chk("crc16_in_pkt", 32'(l16), 32'(e.c16));
                        chk("crc_off_done", 32'({crc5_enable, crc16_enable}), 32'd0);
                        chk("pid_out", 32'(pid_out), 32'(e.pid));
                        chk("byte_count", 32'(byte_count), 32'(e.cnt));
                        chk("pid_err", 32'(pid_err), 32'(e.pe));
                        chk("len_err", 32'(len_err), 32'(e.le));
                        chk("toggle_err", 32'(toggle_err), 32'(e.te));
                        chk("exp_tog", 32'(dut.r_exp_tog), 32'(e.tog));
                    end
                end else begin
                    l5  = crc5_enable;
                    l16 = crc16_enable;
                end
                prev_done = pkt_done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] p;
        logic [7:0] pb;
        rst = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b1;
        tick();

        send_pkt(1, 8'hC3, 4, 0, 0);
        send_pkt(1, 8'hE1, 2, 0, 0);
        send_pkt(1, 8'hA5, 3, 1, 1);
        send_pkt(1, 8'h4B, 1, 1, 0);
        send_pkt(1, 8'h2D, 2, 1, 0);
        send_pkt(1, 8'hC3, 6, 2, 1);
        send_pkt(0, 8'h00, 0, 0, 0);
        send_pkt(1, 8'hC3, 2, 3, 0);
        send_pkt(1, 8'hC3, 4, 0, 1);

        // Second SOP mid-payload aborts the first packet.
        SOP_flag = 1'b1; tick(); SOP_flag = 1'b0;
        byte_valid = 1'b1; byte_in = 8'h4B; tick();
        byte_in = 8'h11; tick(); tick();
        byte_valid = 1'b0;
        SOP_flag = 1'b1; tick(); SOP_flag = 1'b0;
        chk("abort_ds", 32'(data_select), 32'd4);
        chk("abort_cnt", 32'(byte_count), 32'd0);
        chk("abort_no_done", 32'(pkt_done), 32'd0);
        sb_q.push_back(model_pkt(1, 8'hD2, 0, 0));
        byte_valid = 1'b1; byte_in = 8'hD2; tick(); byte_valid = 1'b0;
        EOP_flag = 1'b1; ep_addr = 2'd0; tick(); EOP_flag = 1'b0;
        chk("abort_next_done", 32'(pkt_done), 32'd1);
        tick(); tick();

        // Reset in the middle of a payload.
        SOP_flag = 1'b1; tick(); SOP_flag = 1'b0;
        byte_valid = 1'b1; byte_in = 8'h4B; tick();
        byte_in = 8'h22; tick();
        byte_valid = 1'b0;
        rst = 1'b0; tick();
        chk_reset_vals("midrst");
        m_tog = '0;
        rst = 1'b1; tick();
        chk("midrst_no_done", 32'(pkt_done), 32'd0);

        for (int n = 0; n < 80; n++) begin
            p  = 4'($urandom);
            pb = ($urandom_range(0, 3) != 0) ? {~p, p} : 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                send_pkt(0, 8'h00, 0, $urandom_range(0, 3), 0);
            end else begin
                send_pkt(1, pb, $urandom_range(0, 7), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)));
            end
        end

        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
